// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Opcodes, timesteps, ALU function codes and instruction field
//            positions for the 10-bit processor control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam int RX_LSB = 8;
  localparam int RY_LSB = 6;
  localparam int OP_LSB = 0;
  localparam int OP_W   = 4;

  typedef enum logic [3:0] {
    OP_LOAD = 4'd0,
    OP_COPY = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

  localparam logic [2:0] FN_ADD   = 3'd0;
  localparam logic [2:0] FN_SUB   = 3'd1;
  localparam logic [2:0] FN_AND   = 3'd2;
  localparam logic [2:0] FN_OR    = 3'd3;
  localparam logic [2:0] FN_XOR   = 3'd4;
  localparam logic [2:0] FN_NOT   = 3'd5;
  localparam logic [2:0] FN_PASSB = 3'd6;

  typedef struct packed {
    logic       ext;
    logic       enr;
    logic [1:0] wra;
    logic [1:0] rda0;
    logic [1:0] rda1;
    logic [2:0] fn;
    logic       gout;
    logic       ir_en;
    logic       ain_en;
    logic       gin_en;
    logic       enw_en;
    logic       set_done;
    logic       set_illegal;
    logic       set_halt;
    step_e      next;
  } dec_t;

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

  function automatic logic [2:0] alu_fn(input logic [3:0] op);
    case (op)
      OP_SUB:  return FN_SUB;
      OP_AND:  return FN_AND;
      OP_OR:   return FN_OR;
      OP_XOR:  return FN_XOR;
      OP_NOT:  return FN_NOT;
      default: return FN_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational map from {step, opcode, Rx, Ry} to selectors,
//            strobe enables and next step. HALT decode needs CTRL_HALT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decode
  import ctrl_pkg::*;
(
  input  step_e      step_i,
  input  logic [3:0] op_i,
  input  logic [1:0] rx_i,
  input  logic [1:0] ry_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o      = '0;
    dec_o.next = T0;
    case (step_i)
      T0: begin
        dec_o.ir_en = 1'b1;
        dec_o.next  = T1;
      end
      T1: begin
        case (op_i)
          OP_LOAD: begin
            dec_o.ext      = 1'b1;
            dec_o.wra      = rx_i;
            dec_o.enw_en   = 1'b1;
            dec_o.set_done = 1'b1;
          end
          OP_COPY: begin
            dec_o.enr      = 1'b1;
            dec_o.rda1     = ry_i;
            dec_o.fn       = FN_PASSB;
            dec_o.wra      = rx_i;
            dec_o.enw_en   = 1'b1;
            dec_o.set_done = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            dec_o.enr    = 1'b1;
            dec_o.rda0   = rx_i;
            dec_o.ain_en = 1'b1;
            dec_o.next   = T2;
          end
`ifdef CTRL_HALT_EN
          OP_HALT: begin
            dec_o.set_halt = 1'b1;
            dec_o.set_done = 1'b1;
          end
`endif
          default: dec_o.set_illegal = 1'b1;
        endcase
      end
      // T2/T3 are only reachable by ALU ops unless INSTR changes underneath
      T2: begin
        if (is_alu(op_i)) begin
          dec_o.enr    = 1'b1;
          dec_o.rda1   = ry_i;
          dec_o.fn     = alu_fn(op_i);
          dec_o.gin_en = 1'b1;
          dec_o.next   = T3;
        end
      end
      T3: begin
        if (is_alu(op_i)) begin
          dec_o.gout     = 1'b1;
          dec_o.wra      = rx_i;
          dec_o.enw_en   = 1'b1;
          dec_o.set_done = 1'b1;
        end
      end
      default: dec_o.next = T0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_sequencer.sv
// ============================================================================
// Module   : ctrl_sequencer
// Brief    : Timestep sequencer for the 10-bit processor; holds step, DONE,
//            ILLEGAL and halt flops and gates strobes with STEP.
//            Optional HALT opcode enabled by defining CTRL_HALT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 10,
  parameter int REG_AW  = 2,
  parameter int FN_W    = 3
) (
  input  logic               CLK,
  input  logic               CLRb,
  input  logic               STEP,
  input  logic [INSTR_W-1:0] INSTR,
  output logic               IRin,
  output logic               EXT,
  output logic               ENW,
  output logic [REG_AW-1:0]  WRA,
  output logic               ENR,
  output logic [REG_AW-1:0]  RDA0,
  output logic [REG_AW-1:0]  RDA1,
  output logic [FN_W-1:0]    FN,
  output logic               Ain,
  output logic               Gin,
  output logic               Gout,
  output logic [1:0]         TIME,
  output logic               DONE,
  output logic               ILLEGAL
);

  step_e step_q, step_d;
  logic  done_q, done_d;
  logic  illegal_q, illegal_d;
  logic  halt_q, halt_d;
  dec_t  w_dec;
  logic  w_adv;
  logic  w_unused_rsvd;

  assign w_unused_rsvd = ^INSTR[5:4];

  ctrl_decode u_decode (
    .step_i (step_q),
    .op_i   (INSTR[OP_LSB +: OP_W]),
    .rx_i   (INSTR[RX_LSB +: 2]),
    .ry_i   (INSTR[RY_LSB +: 2]),
    .dec_o  (w_dec)
  );

  assign w_adv = STEP & ~halt_q;

  // CLRb in the gate keeps strobes quiet while reset is held with STEP high
  assign IRin = w_dec.ir_en  & w_adv & CLRb;
  assign Ain  = w_dec.ain_en & w_adv & CLRb;
  assign Gin  = w_dec.gin_en & w_adv & CLRb;
  assign ENW  = w_dec.enw_en & w_adv & CLRb;

  assign EXT  = w_dec.ext;
  assign ENR  = w_dec.enr;
  assign WRA  = w_dec.wra;
  assign RDA0 = w_dec.rda0;
  assign RDA1 = w_dec.rda1;
  assign FN   = w_dec.fn;
  assign Gout = w_dec.gout;

  assign TIME    = step_q;
  assign DONE    = done_q;
  assign ILLEGAL = illegal_q;

  always_comb begin
    step_d    = step_q;
    done_d    = done_q;
    illegal_d = illegal_q;
    halt_d    = halt_q;
    if (w_adv) begin
      step_d = w_dec.next;
      if (w_dec.ir_en) begin
        done_d    = 1'b0;
        illegal_d = 1'b0;
      end
      if (w_dec.set_done)    done_d    = 1'b1;
      if (w_dec.set_illegal) illegal_d = 1'b1;
      if (w_dec.set_halt)    halt_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge CLRb) begin
    if (!CLRb) begin
      step_q    <= T0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      step_q    <= step_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      halt_q    <= halt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
// ============================================================================
// Module   : tb_ctrl_sequencer
// Brief    : Scoreboard bench for ctrl_sequencer; expected per-STEP outputs
//            come from an instruction-level model. Honours CTRL_HALT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_sequencer;

  logic       CLK = 1'b0;
  logic       CLRb;
  logic       STEP;
  logic [9:0] INSTR;
  logic       IRin, EXT, ENW, ENR, Ain, Gin, Gout, DONE, ILLEGAL;
  logic [1:0] WRA, RDA0, RDA1, TIME;
  logic [2:0] FN;

  ctrl_sequencer dut (
    .CLK(CLK), .CLRb(CLRb), .STEP(STEP), .INSTR(INSTR),
    .IRin(IRin), .EXT(EXT), .ENW(ENW), .WRA(WRA), .ENR(ENR),
    .RDA0(RDA0), .RDA1(RDA1), .FN(FN), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .TIME(TIME), .DONE(DONE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // strobe vector {IRin,Ain,Gin,ENW}; selector vector {EXT,ENR,WRA,RDA0,RDA1,FN,Gout}
  localparam logic [3:0] S_IR = 4'b1000, S_AIN = 4'b0100, S_GIN = 4'b0010, S_ENW = 4'b0001;
  localparam int P_EXT = 11, P_ENR = 10, P_WRA = 8, P_RDA0 = 6, P_RDA1 = 4, P_FN = 1, P_GOUT = 0;

  typedef struct {
    logic [3:0]  strb;
    logic [11:0] sel;
    logic [11:0] care;
    logic [1:0]  t;
    logic        done;
    logic        ill;
  } rec_t;

  rec_t exp_q[$];
  rec_t plan[$];
  rec_t mon_r;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic m_done = 1'b0, m_ill = 1'b0;
  logic fin_done, fin_ill;

  logic [3:0]  w_strb;
  logic [11:0] w_sel;
  assign w_strb = {IRin, Ain, Gin, ENW};
  assign w_sel  = {EXT, ENR, WRA, RDA0, RDA1, FN, Gout};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (CLRb === 1'b1 && STEP === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_step: got a STEP cycle want none queued (t=%0t)", $time);
      end else begin
        mon_r = exp_q.pop_front();
        chk("strobes", 32'(w_strb), 32'(mon_r.strb));
        if (mon_r.care != 12'd0)
          chk("selectors", 32'(w_sel & mon_r.care), 32'(mon_r.sel & mon_r.care));
        chk("time", 32'(TIME), 32'(mon_r.t));
        chk("flags", 32'({DONE, ILLEGAL}), 32'({mon_r.done, mon_r.ill}));
      end
    end
  end

  function automatic rec_t blank(input logic [1:0] t);
    rec_t r;
    r.strb = 4'd0; r.sel = 12'd0; r.care = 12'd0;
    r.t = t; r.done = 1'b0; r.ill = 1'b0;
    return r;
  endfunction

  function automatic rec_t fld(input rec_t r0, input int lsb, input int w, input logic [3:0] v);
    rec_t r = r0;
    for (int i = 0; i < w; i++) begin
      r.sel[lsb+i]  = v[i];
      r.care[lsb+i] = 1'b1;
    end
    return r;
  endfunction

  // Instruction-level reference: the micro-step table for one instruction
  task automatic plan_instr(input logic [9:0] ins);
    logic [3:0] op = ins[3:0];
    logic [3:0] rx = {2'b00, ins[9:8]};
    logic [3:0] ry = {2'b00, ins[7:6]};
    rec_t r;
    plan.delete();
    fin_done = 1'b0;
    fin_ill  = 1'b0;
    r = blank(2'd0); r.done = m_done; r.ill = m_ill; r.strb = S_IR;
    plan.push_back(r);
    if (op == 4'd0) begin
      r = blank(2'd1); r.strb = S_ENW;
      r = fld(r, P_EXT, 1, 4'd1); r = fld(r, P_WRA, 2, rx);
      plan.push_back(r);
      fin_done = 1'b1;
    end else if (op == 4'd1) begin
      r = blank(2'd1); r.strb = S_ENW;
      r = fld(r, P_ENR, 1, 4'd1); r = fld(r, P_RDA1, 2, ry); r = fld(r, P_GOUT, 1, 4'd0);
      r = fld(r, P_EXT, 1, 4'd0); r = fld(r, P_FN, 3, 4'd6); r = fld(r, P_WRA, 2, rx);
      plan.push_back(r);
      fin_done = 1'b1;
    end else if (op >= 4'd2 && op <= 4'd7) begin
      r = blank(2'd1); r.strb = S_AIN;
      r = fld(r, P_ENR, 1, 4'd1); r = fld(r, P_RDA0, 2, rx);
      plan.push_back(r);
      r = blank(2'd2); r.strb = S_GIN;
      r = fld(r, P_ENR, 1, 4'd1); r = fld(r, P_RDA1, 2, ry); r = fld(r, P_FN, 3, op - 4'd2);
      plan.push_back(r);
      r = blank(2'd3); r.strb = S_ENW;
      r = fld(r, P_GOUT, 1, 4'd1); r = fld(r, P_EXT, 1, 4'd0); r = fld(r, P_WRA, 2, rx);
      plan.push_back(r);
      fin_done = 1'b1;
    end
`ifdef CTRL_HALT_EN
    else if (op == 4'd15) begin
      plan.push_back(blank(2'd1));
      fin_done = 1'b1;
    end
`endif
    else begin
      plan.push_back(blank(2'd1));
      fin_ill = 1'b1;
    end
  endtask

  task automatic pulse(input int n);
    @(posedge CLK); #1 STEP = 1'b1;
    repeat (n) @(posedge CLK);
    #1 STEP = 1'b0;
  endtask

  task automatic run_instr(input logic [9:0] ins, input int limit, input bit held);
    int n;
    INSTR = ins;
    plan_instr(ins);
    n = (plan.size() < limit) ? plan.size() : limit;
    if (held) begin
      for (int i = 0; i < n; i++) exp_q.push_back(plan[i]);
      pulse(n);
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(plan[i]);
        pulse(1);
        repeat ($urandom_range(0, 2)) @(posedge CLK);
      end
    end
    if (n == plan.size()) begin
      m_done = fin_done;
      m_ill  = fin_ill;
      @(negedge CLK);
      chk("end_time", 32'(TIME), 32'd0);
      chk("end_flags", 32'({DONE, ILLEGAL}), 32'({m_done, m_ill}));
    end
  endtask

  // Reset asserted with STEP high: strobes must stay low
  task automatic do_reset();
    @(posedge CLK); #1 CLRb = 1'b0; STEP = 1'b1;
    @(negedge CLK);
    chk("rst_strobes", 32'(w_strb), 32'd0);
    chk("rst_selectors", 32'(w_sel), 32'd0);
    chk("rst_time", 32'(TIME), 32'd0);
    chk("rst_flags", 32'({DONE, ILLEGAL}), 32'd0);
    @(posedge CLK); #1 CLRb = 1'b1; STEP = 1'b0;
    m_done = 1'b0;
    m_ill  = 1'b0;
  endtask

  initial begin
    logic [9:0] ins;
    logic [3:0] op;
    CLRb  = 1'b0;
    STEP  = 1'b0;
    INSTR = 10'd0;
    do_reset();

    run_instr(10'b10_00_00_0000, 9, 1'b0);   // LOAD R2
    run_instr(10'b01_11_00_0011, 9, 1'b0);   // SUB R1,R3
    run_instr(10'b00_10_00_0010, 9, 1'b1);   // ADD R0,R2 with STEP held
    run_instr(10'b01_01_11_0010, 9, 1'b0);   // ADD R1,R1, reserved bits set
    run_instr(10'b11_00_00_0001, 9, 1'b1);   // COPY R3<-R0 held
    run_instr(10'b00_00_00_1010, 9, 1'b0);   // undefined
    run_instr(10'b10_01_00_0111, 9, 1'b0);   // NOT clears ILLEGAL

    run_instr(10'b11_10_00_0010, 2, 1'b0);   // abort ADD in T2
    do_reset();
    run_instr(10'b11_10_00_0010, 9, 1'b0);

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
`ifdef CTRL_HALT_EN
      if (op == 4'd15) op = 4'd12;
`endif
      ins = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), op};
      run_instr(ins, 9, 1'($urandom_range(0, 1)));
    end

`ifdef CTRL_HALT_EN
    run_instr(10'b00_00_00_1111, 9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rec_t r = blank(2'd0);
      r.done = 1'b1;
      exp_q.push_back(r);
      pulse(1);
    end
    @(negedge CLK);
    chk("halt_time", 32'(TIME), 32'd0);
    do_reset();
    run_instr(10'b01_00_00_0000, 9, 1'b0);
`else
    run_instr(10'b00_00_00_1111, 9, 1'b0);
`endif

    repeat (2) @(posedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
